ble_iq_link_arbiter: RTL
========================

// Module: ble_iq_link_arbiter
// PURPOSE
//   Shares one inter-system BLE IQ sample link between the real (RE) and imaginary (IM) sample streams.
//   Each stream is buffered in its own FIFO. Bursts are arbitrated round-robin onto a single valid/ready link.
//   Sits between one SYSTEM_TOP's BLE IQ outputs and the serializer feeding the peer system.
//   Producers have no backpressure, so the block flags dropped samples in sticky overflow bits.
// PARAMETERS
//   DATA_W      12  IQ sample width (matches RE_IM_SIZE_BLE)
//   FIFO_DEPTH  4   entries per stream FIFO; power of 2, >=2
//   BURST_MAX   4   max consecutive beats granted to one stream while the other waits; >=1
// PORTS
//   SYS_FCLK     in   1       clock; one clock
//   RESET        in   1       reset, asynchronous, active-high
//   enable       in   1       arbitration enable; 0 = no new beats loaded
//   valid_in_re  in   1       RE sample strobe
//   data_in_re   in   DATA_W  RE sample
//   valid_in_im  in   1       IM sample strobe
//   data_in_im   in   DATA_W  IM sample
//   link_valid   out  1       link beat valid
//   link_data    out  DATA_W  link beat sample
//   link_sel     out  1       beat source: 0=RE, 1=IM
//   link_ready   in   1       link sink accepts beat
//   clr_ovf      in   1       clears both overflow flags
//   ovf_re       out  1       sticky: RE sample dropped
//   ovf_im       out  1       sticky: IM sample dropped
// BEHAVIOUR
//   Reset:
//   - all outputs 0; FIFOs empty; state IDLE; beat_cnt 0; rr pointer prefers RE.
//   FIFOs:
//   - push on valid_in_x when not full, or when full and the same cycle pops that FIFO.
//   - otherwise the sample is dropped and ovf_x is set on the next edge.
//   - pointers wrap modulo FIFO_DEPTH; full/empty are tracked with an extra pointer bit.
//   Output register:
//   - load opportunity = enable && (!link_valid || link_ready).
//   - a load pops the selected FIFO into link_data/link_sel and sets link_valid.
//   - link_valid && !link_ready: link_data and link_sel held stable.
//   - accept with no new load: link_valid drops to 0.
//   - latency: a sample pushed at edge N into an empty FIFO with an idle link is on link_valid after edge N+1.
//   FSM states IDLE, OWN_RE, OWN_IM, evaluated at each load opportunity:
//   - IDLE: pick the nonempty stream (both nonempty: rr pointer); go to OWN_x; beat_cnt=1.
//   - OWN_x, x nonempty, beat_cnt<BURST_MAX: load x; beat_cnt++.
//   - OWN_x, burst exhausted or x empty, other stream y nonempty: load y; go to OWN_y; beat_cnt=1; rr pointer -> x.
//   - OWN_x, y empty, x nonempty: load x; beat_cnt=1 (fresh burst).
//   - both empty: go to IDLE; no load.
//   enable=0:
//   - no loads; a pending beat stays until accepted; FSM returns to IDLE; FIFOs keep accepting pushes.
//   Overflow flags:
//   - clr_ovf clears ovf_re and ovf_im; an overflow in the same cycle wins (flag stays 1).
//   RESET mid-burst:
//   - the in-flight beat is discarded; link_valid drops asynchronously.
// CONFIGURATION
//   LINK_PARITY_EN defined:
//   - extra output link_parity (1 bit) = ^{link_sel,link_data}.
//   - registered with the beat; 0 at reset; held with the beat.
//   LINK_PARITY_EN undefined:
//   - port and logic are absent; all other behaviour is identical.
// TESTING
//   T1 single beat:
//   - RE 12'h5A3 pushed, link_ready=1 -> link_valid=1, data=12'h5A3, sel=0 one cycle after push edge; then 0.
//   T2 fairness:
//   - both FIFOs full (RE 1..4, IM 11..14), BURST_MAX=2, ready=1 -> sel order 0,0,1,1,0,0,1,1.
//   - data order 1,2,11,12,3,4,13,14.
//   T3 backpressure:
//   - link_ready=0 for 5 cycles with valid=1 -> link_data/link_sel constant; no pop; FIFO count unchanged.
//   T4 overflow:
//   - 5 RE pushes, link_ready=0 -> 5th dropped, ovf_re=1.
//   - clr_ovf coincident with a 6th drop -> ovf_re stays 1; clr_ovf alone -> 0.
//   T5 full push+pop:
//   - RE FIFO full, ready=1, push same cycle as pop -> no drop, ovf_re=0, count stays 4.
//   T6 reset mid-burst:
//   - assert RESET while link_valid=1 -> outputs 0 immediately.
//   - after release the first beat is from a new push, RE preferred.
//   - with LINK_PARITY_EN: beat 12'h001, sel=1 -> link_parity=0.

Source files
------------

// File: rtl/ble_iq_link_arbiter.sv
// Round-robin burst arbiter sharing one valid/ready BLE IQ link between RE and IM sample FIFOs.
// Optional feature macro: LINK_PARITY_EN adds link_parity = ^{link_sel,link_data}, registered with the beat.
module ble_iq_link_arbiter #(
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 4,
   parameter int BURST_MAX  = 4
) (
   input  logic              SYS_FCLK,
   input  logic              RESET,
   input  logic              enable,
   input  logic              valid_in_re,
   input  logic [DATA_W-1:0] data_in_re,
   input  logic              valid_in_im,
   input  logic [DATA_W-1:0] data_in_im,
   output logic              link_valid,
   output logic [DATA_W-1:0] link_data,
   output logic              link_sel,
   input  logic              link_ready,
   input  logic              clr_ovf,
   output logic              ovf_re,
   output logic              ovf_im
`ifdef LINK_PARITY_EN
   ,
   output logic              link_parity
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(BURST_MAX + 1);

   typedef enum logic [1:0] {IDLE, OWN_RE, OWN_IM} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              rr_q, rr_d;
   logic              vld_q, sel_q;
   logic [DATA_W-1:0] data_q;
   logic              ovf_re_q, ovf_re_d, ovf_im_q, ovf_im_d;

   // Stream index 0 = RE, 1 = IM throughout the FIFO arrays.
   logic [DATA_W-1:0] mem_q [2][FIFO_DEPTH];
   logic [AW:0]       wr_q [2];
   logic [AW:0]       rd_q [2];
   logic [DATA_W-1:0] din [2];
   logic [DATA_W-1:0] dout [2];
   logic [1:0]        push, pop, empty, full, push_ok, drop;

   logic load, load_sel, load_opp;
   logic own, own_ne, oth_ne;

   assign push    = {valid_in_im, valid_in_re};
   assign din[0]  = data_in_re;
   assign din[1]  = data_in_im;
   assign pop     = {load & load_sel, load & ~load_sel};

   always_comb begin
      for (int s = 0; s < 2; s++) begin
         empty[s]   = (wr_q[s] == rd_q[s]);
         full[s]    = (wr_q[s][AW] != rd_q[s][AW]) && (wr_q[s][AW-1:0] == rd_q[s][AW-1:0]);
         push_ok[s] = push[s] && (!full[s] || pop[s]);
         drop[s]    = push[s] && !push_ok[s];
         dout[s]    = mem_q[s][rd_q[s][AW-1:0]];
      end
   end

   always_ff @(posedge SYS_FCLK or posedge RESET) begin
      if (RESET) begin
         for (int s = 0; s < 2; s++) begin
            wr_q[s] <= '0;
            rd_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (push_ok[s]) wr_q[s] <= wr_q[s] + (AW+1)'(1);
            if (pop[s])     rd_q[s] <= rd_q[s] + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge SYS_FCLK) begin
      for (int s = 0; s < 2; s++) begin
         if (push_ok[s]) mem_q[s][wr_q[s][AW-1:0]] <= din[s];
      end
   end

   assign load_opp = enable && (!vld_q || link_ready);
   assign own      = (state_q == OWN_IM);
   assign own_ne   = own ? !empty[1] : !empty[0];
   assign oth_ne   = own ? !empty[0] : !empty[1];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rr_d     = rr_q;
      load     = 1'b0;
      load_sel = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (load_opp) begin
         case (state_q)
            IDLE: begin
               if (!empty[0] || !empty[1]) begin
                  load     = 1'b1;
                  load_sel = (!empty[0] && !empty[1]) ? rr_q : empty[0];
                  state_d  = load_sel ? OWN_IM : OWN_RE;
                  cnt_d    = CW'(1);
               end
            end
            default: begin
               if (own_ne && (cnt_q < CW'(BURST_MAX))) begin
                  load     = 1'b1;
                  load_sel = own;
                  cnt_d    = cnt_q + CW'(1);
               end else if (oth_ne) begin
                  // Hand over to the waiting stream; rr remembers the previous owner.
                  load     = 1'b1;
                  load_sel = !own;
                  state_d  = own ? OWN_RE : OWN_IM;
                  cnt_d    = CW'(1);
                  rr_d     = own;
               end else if (own_ne) begin
                  load     = 1'b1;
                  load_sel = own;
                  cnt_d    = CW'(1);
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
         endcase
      end
   end

   assign ovf_re_d = drop[0] | (ovf_re_q & ~clr_ovf);
   assign ovf_im_d = drop[1] | (ovf_im_q & ~clr_ovf);

   always_ff @(posedge SYS_FCLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rr_q     <= 1'b0;
         vld_q    <= 1'b0;
         sel_q    <= 1'b0;
         data_q   <= '0;
         ovf_re_q <= 1'b0;
         ovf_im_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rr_q     <= rr_d;
         ovf_re_q <= ovf_re_d;
         ovf_im_q <= ovf_im_d;
         if (load) begin
            vld_q  <= 1'b1;
            sel_q  <= load_sel;
            data_q <= load_sel ? dout[1] : dout[0];
         end else if (link_ready) begin
            vld_q <= 1'b0;
         end
      end
   end

`ifdef LINK_PARITY_EN
   logic parity_q;
   always_ff @(posedge SYS_FCLK or posedge RESET) begin
      if (RESET)     parity_q <= 1'b0;
      else if (load) parity_q <= ^{load_sel, (load_sel ? dout[1] : dout[0])};
   end
   assign link_parity = parity_q;
`endif

   assign link_valid = vld_q;
   assign link_data  = data_q;
   assign link_sel   = sel_q;
   assign ovf_re     = ovf_re_q;
   assign ovf_im     = ovf_im_q;

endmodule
